// File: rtl/systick_timer.sv
// systick_timer: memory-mapped down-counting tick timer with an 8-bit
// prescaler. Raises a level interrupt request (do_systick_it) when the
// counter steps from 1 to 0 with TICKINT set; the request is held until the
// interrupt sequencer pulses it_ack.
module systick_timer #(
    parameter int          CNT_W     = 24,
    parameter logic [31:0] CALIB_VAL = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_system,
    input  logic        st_cs,
    input  logic        st_we,
    input  logic [1:0]  st_addr,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_rdata,
    input  logic        it_ack,
    output logic        do_systick_it
);

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_LOAD  = 2'd1;
    localparam logic [1:0] ADDR_VAL   = 2'd2;
    localparam logic [1:0] ADDR_CALIB = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             ctrl_enable;
    logic             ctrl_tickint;
    logic [7:0]       ctrl_presc;
    logic             countflag;
    logic [CNT_W-1:0] load;
    logic [CNT_W-1:0] val;
    logic [7:0]       presc_cnt;
    logic             pending;
    logic [31:0]      rdata;
    logic [31:0]      read_mux;

    logic wr_ctrl;
    logic wr_load;
    logic wr_val;
    logic rd_ctrl;
    logic rd_any;
    logic run;
    logic tick;
    logic flag_set;
    logic pend_set;
    logic restart;

    // Only a subset of write-data bits lands in registers; fold the rest away.
    logic wdata_unused;
    assign wdata_unused = ^st_wdata;

    // Zero-extend a counter-width value onto the 32-bit bus.
    function automatic logic [31:0] widen(input logic [CNT_W-1:0] v);
        logic [31:0] r;
        r = '0;
        r[CNT_W-1:0] = v;
        return r;
    endfunction

    assign wr_ctrl = st_cs && st_we && (st_addr == ADDR_CTRL);
    assign wr_load = st_cs && st_we && (st_addr == ADDR_LOAD);
    assign wr_val  = st_cs && st_we && (st_addr == ADDR_VAL);
    assign rd_any  = st_cs && !st_we;
    assign rd_ctrl = rd_any && (st_addr == ADDR_CTRL);

    assign run  = ctrl_enable && enable_system;
    assign tick = run && (presc_cnt == ctrl_presc);

    // A VAL write discards the tick that would otherwise land on the same edge.
    assign flag_set = tick && !wr_val && (val == CNT_ONE);
    assign pend_set = flag_set && ctrl_tickint;

    // Prescaler restarts on any VAL write or when ENABLE goes 0 -> 1.
    assign restart = wr_val || (wr_ctrl && st_wdata[0] && !ctrl_enable);

    // CTRL configuration fields (COUNTFLAG lives in its own register).
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_enable  <= 1'b0;
            ctrl_tickint <= 1'b0;
            ctrl_presc   <= '0;
        end else if (wr_ctrl) begin
            ctrl_enable  <= st_wdata[0];
            ctrl_tickint <= st_wdata[1];
            ctrl_presc   <= st_wdata[15:8];
        end
    end

    // Prescaler: counts 0..PRESC while running, wraps on the tick cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if (restart) begin
            presc_cnt <= '0;
        end else if (run) begin
            presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
        end
    end

    // Reload value; bits above CNT_W are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            load <= '0;
        end else if (wr_load) begin
            load <= st_wdata[CNT_W-1:0];
        end
    end

    // Down-counter: reload from 0, otherwise decrement on each tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            val <= '0;
        end else if (wr_val) begin
            val <= '0;
        end else if (tick) begin
            if (val == '0) begin
                val <= load;
            end else begin
                val <= val - CNT_ONE;
            end
        end
    end

    // COUNTFLAG: a fresh set beats the clear-on-read of the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            countflag <= 1'b0;
        end else if (wr_val) begin
            countflag <= 1'b0;
        end else if (flag_set) begin
            countflag <= 1'b1;
        end else if (rd_ctrl) begin
            countflag <= 1'b0;
        end
    end

    // Interrupt request: set beats ack; dropped if TICKINT is cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (pend_set) begin
            pending <= 1'b1;
        end else if (it_ack || !ctrl_tickint) begin
            pending <= 1'b0;
        end
    end

    // Read multiplexer over current register contents.
    always_comb begin
        read_mux = '0;
        case (st_addr)
            ADDR_CTRL:  read_mux = {15'd0, countflag, ctrl_presc, 6'd0,
                                    ctrl_tickint, ctrl_enable};
            ADDR_LOAD:  read_mux = widen(load);
            ADDR_VAL:   read_mux = widen(val);
            ADDR_CALIB: read_mux = CALIB_VAL;
            default:    read_mux = '0;
        endcase
    end

    // Registered read data, held between accesses.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_any) begin
            rdata <= read_mux;
        end
    end

    assign st_rdata      = rdata;
    assign do_systick_it = pending;

endmodule
